// File: rtl/axis_pkg.sv
// Shared types and width helpers for the AXI-Stream slave FIFO.
package axis_pkg;

    localparam int AXIS_DEF_WIDTH  = 32;
    localparam int AXIS_DEF_USER_W = 1;

    // Reference beat layout {last, user, data}; modules rebuild it at their own widths.
    typedef struct packed {
        logic                       last;
        logic [AXIS_DEF_USER_W-1:0] user;
        logic [AXIS_DEF_WIDTH-1:0]  data;
    } axis_beat_t;

    function automatic int clog2_p1(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int beat_w(input int width, input int user_w);
        return width + user_w + 1;
    endfunction

endpackage

// File: rtl/axis_s_fifo_mem.sv
// Beat storage for axis_s_fifo: synchronous write, asynchronous read, no reset.
module axis_s_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 34,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_s_fifo.sv
// AXI-Stream slave FIFO with first-word-fall-through output, occupancy and almost-full.
// Define AXIS_S_PKT_MODE_EN for store-and-forward packet mode.
module axis_s_fifo
    import axis_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int USER_W    = 1,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int CW       = clog2_p1(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  s_axis_tdata,
    input  logic [USER_W-1:0] s_axis_tuser,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              ready,
    output logic              valid_out,
    output logic [WIDTH-1:0]  data_out,
    output logic [USER_W-1:0] user_out,
    output logic              last_out,
    output logic [CW-1:0]     count,
    output logic              al_full,
    output logic [CW-1:0]     pkt_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = beat_w(WIDTH, USER_W);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic              last;
        logic [USER_W-1:0] user;
        logic [WIDTH-1:0]  data;
    } beat_t;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rdy_en;
    logic          full;
    logic          has_data;
    logic          push;
    logic          pop;
    beat_t         wr_beat;
    beat_t         head;
    logic [BW-1:0] rd_word;

    assign full          = (count == FULL_CNT);
    assign has_data      = (count != '0);
    // tready depends only on registered state, never on downstream ready.
    assign s_axis_tready = rdy_en & ~full;
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = valid_out & ready;
    assign al_full       = (int'(count) >= AF_THRESH);

    assign wr_beat.last = s_axis_tlast;
    assign wr_beat.user = s_axis_tuser;
    assign wr_beat.data = s_axis_tdata;

    axis_s_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (BW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_beat),
        .raddr (rd_ptr),
        .rdata (rd_word)
    );

    assign head     = beat_t'(rd_word);
    assign data_out = head.data;
    assign user_out = head.user;
    assign last_out = head.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef AXIS_S_PKT_MODE_EN
    logic [CW-1:0] pkt_cnt_q;
    logic          pkt_in;
    logic          pkt_out;

    assign pkt_in  = push & s_axis_tlast;
    assign pkt_out = pop & last_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            unique case ({pkt_in, pkt_out})
                2'b10:   pkt_cnt_q <= pkt_cnt_q + CW'(1);
                2'b01:   pkt_cnt_q <= pkt_cnt_q - CW'(1);
                default: pkt_cnt_q <= pkt_cnt_q;
            endcase
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    // A full buffer with no complete packet releases beats so oversize packets cannot deadlock.
    assign valid_out = has_data & ((pkt_cnt_q != '0) | full);
`else
    assign pkt_cnt   = '0;
    assign valid_out = has_data;
`endif

endmodule
